// File: rtl/beat_anim_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | beat_anim_scheduler: queues qualifying beats and fires them into          |
// | animate_controller with acknowledge checking and holdoff. Option macro:    |
// | FRAME_ALIGN_EN (adds an ARM state that waits for frame_start). Rev 1.0     |
// +----------------------------------------------------------------------------+
module beat_anim_scheduler #(
  parameter int CLK_FREQ_HZ  = 50_000_000,
  parameter int HOLDOFF_MS   = 50,
  parameter int ACK_TIMEOUT  = 16,
  parameter int QUEUE_DEPTH  = 4,
  parameter int STRENGTH_MIN = 16,
  parameter int DATA_WIDTH   = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           beat_in,
  input  logic [DATA_WIDTH-1:0]          beat_strength,
  input  logic                           anim_busy,
  input  logic                           frame_start,
  output logic                           beat_trigger,
  output logic [DATA_WIDTH-1:0]          strength_out,
  output logic [$clog2(QUEUE_DEPTH):0]   queue_level,
  output logic [7:0]                     drop_count,
  output logic                           ack_error,
  output logic                           sched_busy
);

  localparam int HOLDOFF_TICKS = (CLK_FREQ_HZ / 1000) * HOLDOFF_MS;
  localparam int PTR_W         = $clog2(QUEUE_DEPTH);
  localparam int LVL_W         = PTR_W + 1;
  localparam int HO_W          = $clog2(HOLDOFF_TICKS + 2);
  localparam int ACK_W         = $clog2(ACK_TIMEOUT + 2);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ARM      = 3'd1,
    S_FIRE     = 3'd2,
    S_WAIT_ACK = 3'd3,
    S_RUN      = 3'd4,
    S_HOLDOFF  = 3'd5
  } state_t;

  state_t                 state_q, state_d;
  logic [DATA_WIDTH-1:0]  mem_q [QUEUE_DEPTH];
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]       level_q, level_d;
  logic [7:0]             drop_q, drop_d;
  logic [ACK_W-1:0]       ack_cnt_q, ack_cnt_d;
  logic [HO_W-1:0]        ho_cnt_q, ho_cnt_d;
  logic                   ack_err_q, ack_err_d;
  logic                   trigger_q, trigger_d;
  logic [DATA_WIDTH-1:0]  strength_q, strength_d;
  logic                   push_req, full, pop, push_ok;

`ifndef FRAME_ALIGN_EN
  logic unused_frame_start;
  assign unused_frame_start = frame_start;
`endif

  // A full queue still takes a new beat when the head leaves in the same cycle.
  always_comb begin
    push_req = beat_in && (beat_strength >= DATA_WIDTH'(STRENGTH_MIN));
    full     = (level_q == LVL_W'(QUEUE_DEPTH));
    pop      = (state_q == S_FIRE);
    push_ok  = push_req && (!full || pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    drop_d   = drop_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)     rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push_ok, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
    if (push_req && full && !pop && (drop_q != 8'hFF)) drop_d = drop_q + 8'd1;
  end

  always_comb begin
    state_d    = state_q;
    ack_cnt_d  = ack_cnt_q;
    ho_cnt_d   = ho_cnt_q;
    ack_err_d  = ack_err_q;
    strength_d = strength_q;
    case (state_q)
      S_IDLE: begin
        if ((level_q != '0) && !anim_busy) begin
`ifdef FRAME_ALIGN_EN
          state_d = S_ARM;
`else
          state_d = S_FIRE;
`endif
        end
      end
      S_ARM: begin
`ifdef FRAME_ALIGN_EN
        if (frame_start && !anim_busy) state_d = S_FIRE;
`else
        state_d = S_IDLE;
`endif
      end
      S_FIRE: begin
        state_d   = S_WAIT_ACK;
        ack_cnt_d = '0;
      end
      S_WAIT_ACK: begin
        if (anim_busy) begin
          state_d = S_RUN;
        end else if (ack_cnt_q == ACK_W'(ACK_TIMEOUT - 1)) begin
          ack_err_d = 1'b1;
          state_d   = S_HOLDOFF;
          ho_cnt_d  = '0;
        end else begin
          ack_cnt_d = ack_cnt_q + ACK_W'(1);
        end
      end
      S_RUN: begin
        if (!anim_busy) begin
          state_d  = S_HOLDOFF;
          ho_cnt_d = '0;
        end
      end
      S_HOLDOFF: begin
        if (ho_cnt_q == HO_W'(HOLDOFF_TICKS - 1)) state_d = S_IDLE;
        else                                      ho_cnt_d = ho_cnt_q + HO_W'(1);
      end
      default: state_d = S_IDLE;
    endcase
    // Strength is captured on entry to FIRE so it is valid alongside the pulse.
    trigger_d = (state_d == S_FIRE);
    if (trigger_d) strength_d = mem_q[rd_ptr_q];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      drop_q     <= '0;
      ack_cnt_q  <= '0;
      ho_cnt_q   <= '0;
      ack_err_q  <= 1'b0;
      trigger_q  <= 1'b0;
      strength_q <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      drop_q     <= drop_d;
      ack_cnt_q  <= ack_cnt_d;
      ho_cnt_q   <= ho_cnt_d;
      ack_err_q  <= ack_err_d;
      trigger_q  <= trigger_d;
      strength_q <= strength_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= beat_strength;
  end

  assign beat_trigger = trigger_q;
  assign strength_out = strength_q;
  assign queue_level  = level_q;
  assign drop_count   = drop_q;
  assign ack_error    = ack_err_q;
  assign sched_busy   = (state_q != S_IDLE) || (level_q != '0);

endmodule
`default_nettype wire
